// File: rtl/hbridge_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : hbridge_cmd_decoder
//  Description : Receives the 4-bit direction bus from the line-follower
//                controller, synchronises and debounces it, decodes it into
//                per-motor drive requests and runs one dead-time / soft-start
//                FSM per H-bridge channel (A and B) sharing one PWM counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hbridge_cmd_decoder #(
    parameter int CNT_W         = 8,
    parameter int DUTY_MAX      = 255,
    parameter int RAMP_STEP     = 8,
    parameter int DEAD_CYCLES   = 1000,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] ctrl_in,
    input  logic       estop,
    output logic       ena_a,
    output logic       in1_a,
    output logic       in2_a,
    output logic       ena_b,
    output logic       in1_b,
    output logic       in2_b,
    output logic       code_err,
    output logic [1:0] state_a,
    output logic [1:0] state_b
);

    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

    localparam logic [STAB_W-1:0] C_STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [DEAD_W-1:0] C_DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W:0]    C_STEP_EXT  = (CNT_W+1)'(RAMP_STEP);
    localparam logic [CNT_W:0]    C_MAX_EXT   = (CNT_W+1)'(DUTY_MAX);
    localparam logic [CNT_W-1:0]  C_DUTY_MAX  = CNT_W'(DUTY_MAX);

    // Per-motor FSM states
    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_DEAD = 2'b01;
    localparam logic [1:0] ST_RAMP = 2'b10;
    localparam logic [1:0] ST_RUN  = 2'b11;

    // Drive requests / latched directions
    localparam logic [1:0] REQ_OFF = 2'b00;
    localparam logic [1:0] DIR_FWD = 2'b01;
    localparam logic [1:0] DIR_REV = 2'b10;

    logic [3:0]        sync1_q, sync2_q;
    logic [3:0]        cand_q;
    logic [STAB_W-1:0] stab_q;
    logic [3:0]        cmd_q;
    logic              code_err_q;
    logic [CNT_W-1:0]  pwm_cnt_q;

    logic              illegal;
    logic              wrap;
    logic [1:0]        req [2];

    logic [1:0]        ena_v, in1_v, in2_v;
    logic [1:0]        state_v [2];

    // Two-flop synchroniser followed by a stability filter on the raw code
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            stab_q  <= '0;
            cmd_q   <= '0;
        end else begin
            sync1_q <= ctrl_in;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                stab_q <= '0;
            end else if (stab_q != C_STAB_LAST) begin
                stab_q <= stab_q + 1'b1;
            end else begin
                cmd_q <= cand_q;
            end
        end
    end

    // Decode the accepted code into per-motor requests; estop or a bad code coasts both
    always_comb begin
        case (cmd_q)
            4'b0000, 4'b1001, 4'b0110, 4'b0101, 4'b1010: illegal = 1'b0;
            default:                                     illegal = 1'b1;
        endcase
        req[0] = (estop || illegal) ? REQ_OFF : cmd_q[1:0];
        req[1] = (estop || illegal) ? REQ_OFF : {cmd_q[2], cmd_q[3]};
    end

    // Shared free-running PWM counter and registered illegal-code flag
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt_q  <= '0;
            code_err_q <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            code_err_q <= illegal;
        end
    end

    assign wrap = &pwm_cnt_q;

    generate
        for (genvar m = 0; m < 2; m++) begin : g_motor
            logic [1:0]        state_q, state_d;
            logic [1:0]        dir_q, dir_d;
            logic [DEAD_W-1:0] dcnt_q, dcnt_d;
            logic [CNT_W-1:0]  duty_q, duty_d;
            logic [CNT_W:0]    duty_sum;
            logic [CNT_W-1:0]  duty_sat;
            logic              ena_q, in1_q, in2_q;
            logic              ena_d, in1_d, in2_d;

            // State, direction, dead counter, duty and bridge output registers
            always_ff @(posedge clock) begin
                if (reset) begin
                    state_q <= ST_OFF;
                    dir_q   <= REQ_OFF;
                    dcnt_q  <= '0;
                    duty_q  <= '0;
                    ena_q   <= 1'b0;
                    in1_q   <= 1'b0;
                    in2_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    dir_q   <= dir_d;
                    dcnt_q  <= dcnt_d;
                    duty_q  <= duty_d;
                    ena_q   <= ena_d;
                    in1_q   <= in1_d;
                    in2_q   <= in2_d;
                end
            end

            // Next state: dead time on every direction change, duty ramp at PWM wrap
            always_comb begin
                state_d  = state_q;
                dir_d    = dir_q;
                dcnt_d   = dcnt_q;
                duty_d   = duty_q;
                duty_sum = {1'b0, duty_q} + C_STEP_EXT;
                duty_sat = (duty_sum >= C_MAX_EXT) ? C_DUTY_MAX : duty_sum[CNT_W-1:0];
                case (state_q)
                    ST_OFF: begin
                        duty_d = '0;
                        if (req[m] != REQ_OFF) begin
                            dir_d   = req[m];
                            dcnt_d  = '0;
                            state_d = ST_DEAD;
                        end
                    end
                    ST_DEAD: begin
                        duty_d = '0;
                        if (req[m] == REQ_OFF) begin
                            state_d = ST_OFF;
                        end else if (req[m] != dir_q) begin
                            dir_d  = req[m];
                            dcnt_d = '0;
                        end else if (dcnt_q == C_DEAD_LAST) begin
                            state_d = ST_RAMP;
                        end else begin
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end
                    ST_RAMP, ST_RUN: begin
                        if (req[m] == REQ_OFF) begin
                            state_d = ST_OFF;
                            duty_d  = '0;
                        end else if (req[m] != dir_q) begin
                            dir_d   = req[m];
                            dcnt_d  = '0;
                            duty_d  = '0;
                            state_d = ST_DEAD;
                        end else if ((state_q == ST_RAMP) && wrap) begin
                            duty_d = duty_sat;
                            if (duty_sat == C_DUTY_MAX) begin
                                state_d = ST_RUN;
                            end
                        end
                    end
                    default: state_d = ST_OFF;
                endcase
            end

            // Bridge outputs: drive only in RAMP/RUN; an OFF request blanks them at once
            always_comb begin
                ena_d = 1'b0;
                in1_d = 1'b0;
                in2_d = 1'b0;
                if ((req[m] != REQ_OFF) && ((state_q == ST_RAMP) || (state_q == ST_RUN))) begin
                    ena_d = (pwm_cnt_q < duty_q);
                    in1_d = (dir_q == DIR_FWD);
                    in2_d = (dir_q == DIR_REV);
                end
            end

            assign ena_v[m]   = ena_q;
            assign in1_v[m]   = in1_q;
            assign in2_v[m]   = in2_q;
            assign state_v[m] = state_q;
        end
    endgenerate

    assign ena_a    = ena_v[0];
    assign in1_a    = in1_v[0];
    assign in2_a    = in2_v[0];
    assign ena_b    = ena_v[1];
    assign in1_b    = in1_v[1];
    assign in2_b    = in2_v[1];
    assign state_a  = state_v[0];
    assign state_b  = state_v[1];
    assign code_err = code_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hbridge_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hbridge_cmd_decoder
//  Description : Directed self-checking bench for hbridge_cmd_decoder with
//                CNT_W=4, DUTY_MAX=15, RAMP_STEP=4, DEAD_CYCLES=8,
//                STABLE_CYCLES=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hbridge_cmd_decoder;

    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_DEAD = 2'b01;
    localparam logic [1:0] ST_RAMP = 2'b10;
    localparam logic [1:0] ST_RUN  = 2'b11;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] ctrl_in;
    logic       estop;
    logic       ena_a, in1_a, in2_a, ena_b, in1_b, in2_b;
    logic       code_err;
    logic [1:0] state_a, state_b;

    int checks = 0;
    int errors = 0;

    hbridge_cmd_decoder #(
        .CNT_W         (4),
        .DUTY_MAX      (15),
        .RAMP_STEP     (4),
        .DEAD_CYCLES   (8),
        .STABLE_CYCLES (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ctrl_in  (ctrl_in),
        .estop    (estop),
        .ena_a    (ena_a),
        .in1_a    (in1_a),
        .in2_a    (in2_a),
        .ena_b    (ena_b),
        .in1_b    (in1_b),
        .in2_b    (in2_b),
        .code_err (code_err),
        .state_a  (state_a),
        .state_b  (state_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {ena_a, in1_a, in2_a, ena_b, in1_b, in2_b};
    endfunction

    task automatic wait_state_a(input logic [1:0] st, input int bound, input string tag);
        int n;
        n = 0;
        while ((state_a !== st) && (n < bound)) begin
            tick();
            n++;
        end
        chk(tag, (state_a === st), 1'b1);
    endtask

    // Shoot-through must never appear on either bridge
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            chk("no_shoot_a", in1_a & in2_a, 1'b0);
            chk("no_shoot_b", in1_b & in2_b, 1'b0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_duty [5];
        int na, nb, zc, n;
        bit seen;
        exp_duty = '{0, 4, 8, 12, 15};

        reset   = 1'b1;
        ctrl_in = 4'b0000;
        estop   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_outs", outs(), 6'b0);
        chk("rst_state_a", state_a, ST_OFF);
        chk("rst_state_b", state_b, ST_OFF);
        chk("rst_code_err", code_err, 1'b0);
        chk("rst_cmd", dut.cmd_q, 4'b0000);

        // Forward: accept on 7th edge, 8 clocks DEAD, then ramp 0/4/8/12/15
        reset   = 1'b0;
        ctrl_in = 4'b1001;
        repeat (6) tick();
        chk("fwd_cmd_edge6", dut.cmd_q, 4'b0000);
        tick();
        chk("fwd_cmd_edge7", dut.cmd_q, 4'b1001);
        tick();
        chk("fwd_dead_a", state_a, ST_DEAD);
        chk("fwd_dead_b", state_b, ST_DEAD);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("fwd_dead_hold", {state_a, state_b}, {ST_DEAD, ST_DEAD});
            chk("fwd_dead_outs", outs(), 6'b0);
        end
        tick();
        chk("fwd_ramp_state", {state_a, state_b}, {ST_RAMP, ST_RAMP});
        chk("fwd_ramp_outs_lag", outs(), 6'b0);
        tick();
        chk("fwd_dir", {in1_a, in2_a, in1_b, in2_b}, 4'b1010);
        for (int w = 0; w < 5; w++) begin
            na = 0;
            nb = 0;
            for (int i = 0; i < 16; i++) begin
                na += int'(ena_a);
                nb += int'(ena_b);
                tick();
            end
            chk("fwd_duty_a", na, exp_duty[w]);
            chk("fwd_duty_b", nb, exp_duty[w]);
        end
        chk("fwd_run", {state_a, state_b}, {ST_RUN, ST_RUN});

        // Three-clock glitch to 0110 must be filtered out
        ctrl_in = 4'b0110;
        repeat (3) tick();
        ctrl_in = 4'b1001;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("glitch_cmd", dut.cmd_q, 4'b1001);
            chk("glitch_state", {state_a, state_b}, {ST_RUN, ST_RUN});
            chk("glitch_dir", {in1_a, in2_a, in1_b, in2_b}, 4'b1010);
        end

        // Reversal: exactly 8 all-zero clocks, then backward with duty from 0
        ctrl_in = 4'b0110;
        zc   = 0;
        seen = 1'b0;
        n    = 0;
        while (n < 60) begin
            tick();
            n++;
            if (outs() == 6'b0) begin
                zc++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        chk("rev_bounded", (n < 60), 1'b1);
        chk("rev_zero_clocks", zc, 8);
        chk("rev_dir", {in1_a, in2_a, in1_b, in2_b}, 4'b0101);
        chk("rev_ena_start", {ena_a, ena_b}, 2'b00);
        chk("rev_state", {state_a, state_b}, {ST_RAMP, ST_RAMP});
        wait_state_a(ST_RUN, 200, "rev_reach_run");

        // Illegal code forces coast and raises code_err
        ctrl_in = 4'b1111;
        repeat (7) tick();
        chk("ill_cmd", dut.cmd_q, 4'b1111);
        chk("ill_err_lag", code_err, 1'b0);
        tick();
        chk("ill_err", code_err, 1'b1);
        chk("ill_state", {state_a, state_b}, {ST_OFF, ST_OFF});
        chk("ill_outs", outs(), 6'b0);
        ctrl_in = 4'b0000;
        repeat (7) tick();
        chk("stop_cmd", dut.cmd_q, 4'b0000);
        tick();
        chk("stop_err_clear", code_err, 1'b0);
        repeat (5) tick();
        chk("stop_state", {state_a, state_b}, {ST_OFF, ST_OFF});
        chk("stop_outs", outs(), 6'b0);

        // Right turn, estop, release
        ctrl_in = 4'b0101;
        wait_state_a(ST_RUN, 300, "right_reach_run");
        chk("right_state_b", state_b, ST_RUN);
        chk("right_dir", {in1_a, in2_a, in1_b, in2_b}, 4'b1001);
        estop = 1'b1;
        tick();
        chk("estop_state", {state_a, state_b}, {ST_OFF, ST_OFF});
        chk("estop_outs", outs(), 6'b0);
        estop = 1'b0;
        tick();
        chk("estop_rel_dead", {state_a, state_b}, {ST_DEAD, ST_DEAD});
        n = 1;
        while ((state_a === ST_DEAD) && (n < 20)) begin
            tick();
            if (state_a === ST_DEAD) n++;
        end
        chk("estop_rel_dead_len", n, 8);
        chk("estop_rel_ramp", {state_a, state_b}, {ST_RAMP, ST_RAMP});
        tick();
        chk("estop_rel_dir", {in1_a, in2_a, in1_b, in2_b}, 4'b1001);
        chk("estop_rel_ena0", {ena_a, ena_b}, 2'b00);

        // Left turn, reset mid-ramp, then full re-acceptance latency
        ctrl_in = 4'b1010;
        wait_state_a(ST_DEAD, 40, "left_reach_dead");
        wait_state_a(ST_RAMP, 40, "left_reach_ramp");
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_outs", outs(), 6'b0);
        chk("mid_rst_state", {state_a, state_b}, {ST_OFF, ST_OFF});
        chk("mid_rst_err", code_err, 1'b0);
        chk("mid_rst_cmd", dut.cmd_q, 4'b0000);
        chk("mid_rst_pwm", dut.pwm_cnt_q, 4'h0);
        chk("mid_rst_duty_a", dut.g_motor[0].duty_q, 4'h0);
        chk("mid_rst_duty_b", dut.g_motor[1].duty_q, 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rel_cmd_wait", dut.cmd_q, 4'b0000);
        end
        tick();
        chk("rel_cmd_edge7", dut.cmd_q, 4'b1010);
        tick();
        chk("rel_dead", {state_a, state_b}, {ST_DEAD, ST_DEAD});
        chk("rel_outs", outs(), 6'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hbridge_cmd_decoder.md
Name: hbridge_cmd_decoder

Overview:
- Receiving end of the 4-bit direction control bus that the line-follower controller drives on JA1..JA4.
- Synchronises and debounces the incoming code, then decodes it into per-motor drive commands for a dual H-bridge (two EN/IN1/IN2 sets, motor A and motor B).
- Enforces dead time on every drive change and soft-starts each motor with a ramped PWM duty.
- Illegal codes and estop force both motors to coast.

Parameters:
- CNT_W, 8, PWM counter and duty width; PWM period = 2^CNT_W clocks.
- DUTY_MAX, 255, saturation duty and RUN duty; range 1..2^CNT_W-1.
- RAMP_STEP, 8, duty increment applied per PWM period while ramping.
- DEAD_CYCLES, 1000, clocks with all bridge inputs low before a newly latched direction is driven.
- STABLE_CYCLES, 4, consecutive equal synchronised samples required to accept a code; minimum 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ctrl_in  in  4  asynchronous direction code from the controller; bit0 = JA1 … bit3 = JA4
- estop  in  1  synchronous emergency stop, active-high
- ena_a, in1_a, in2_a  out  1 each  motor A bridge enable (PWM) and direction inputs
- ena_b, in1_b, in2_b  out  1 each  motor B bridge enable (PWM) and direction inputs
- code_err  out  1  high while the accepted code is illegal
- state_a, state_b  out  2 each  per-motor FSM state

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. On reset, all outputs are 0 and states are OFF. Synchroniser flops, candidate code, accepted cmd, pwm_cnt and duty are all 0.
- Input path: 2-flop synchroniser to s, then filter.
  - If s != cand: cand <= s, stab <= 0.
  - Else if stab != STABLE_CYCLES-1: stab increments.
  - When stab == STABLE_CYCLES-1 and s == cand: cmd <= cand.
  - cmd updates on clock edge STABLE_CYCLES+3 after ctrl_in settles.
  - Any input pulse shorter than STABLE_CYCLES+1 clocks is ignored.
- Decode of cmd. Legal codes and their requests:
  - 0000 stop: A OFF, B OFF.
  - 1001 forward: A FWD, B FWD.
  - 0110 backward: A REV, B REV.
  - 0101 right: A FWD, B REV.
  - 1010 left: A REV, B FWD.
  - Bit mapping: motor A FWD = bit0, REV = bit1. Motor B FWD = bit3, REV = bit2.
  - Any other code: code_err = 1 and both requests are OFF.
- Stop override: estop or code_err forces both requests to OFF.
- pwm_cnt: free-running, increments every clock, wraps from 2^CNT_W-1 to 0. "Wrap" means the edge where pwm_cnt == 2^CNT_W-1.
- Per-motor FSM. All outputs are registered, one-cycle latency from state.
  - OFF (00): ena = in1 = in2 = 0, duty = 0. A request of FWD or REV latches dir, clears the dead counter and goes to DEAD.
  - DEAD (01): ena = in1 = in2 = 0.
    - Request OFF: go to OFF.
    - Request differs from latched dir: relatch dir and restart the counter.
    - After DEAD_CYCLES clocks: go to RAMP with duty = 0.
  - RAMP (10): in1 = (dir == FWD), in2 = (dir == REV).
    - ena = (pwm_cnt < duty).
    - At each wrap, duty <= min(duty + RAMP_STEP, DUTY_MAX), computed at CNT_W+1 bits.
    - When duty reaches DUTY_MAX: go to RUN.
  - RUN (11): same outputs as RAMP, duty held at DUTY_MAX.
  - In RAMP or RUN:
    - Request OFF: go to OFF next edge.
    - Opposite direction: relatch dir, go to DEAD.
    - Same direction: no change.
- Invariants:
  - in1 & in2 is never 1.
  - The bridge direction never flips without at least DEAD_CYCLES clocks of all-zero outputs in between.
  - Both motors run independent FSMs sharing one pwm_cnt.
- Reset mid-operation: all outputs 0 on the next edge, regardless of state.
- Simultaneous events: estop and a cmd change on the same edge resolve to estop (OFF). A reset asserted together with any other event resolves to reset.

Test Plan (bench params CNT_W=4, DUTY_MAX=15, RAMP_STEP=4, DEAD_CYCLES=8, STABLE_CYCLES=4):
- Reset, then ctrl_in=1001 held.
  - cmd = 1001 on the 7th edge.
  - Both states DEAD for 8 clocks with all outputs 0.
  - Then RAMP with in1_a = in1_b = 1, in2 = 0.
  - Duty steps 0, 4, 8, 12, 15 at successive wraps; ena high for duty of 16 clocks; state RUN at 15.
- RUN forward, then ctrl_in=0110.
  - All six bridge outputs 0 for exactly 8 clocks.
  - Then in2_a = in2_b = 1 with duty restarting at 0.
  - in1 & in2 never both 1.
- RUN forward, then ctrl_in=0110 pulsed for 3 clocks and returned to 1001.
  - cmd stays 1001; outputs and states unchanged.
- ctrl_in=1111.
  - code_err = 1 and both motors OFF one edge after cmd update.
  - ctrl_in=0000: code_err = 0, states stay OFF.
- RUN right (0101): in1_a = 1, in2_b = 1.
  - estop=1: all outputs 0 and states OFF next edge.
  - estop=0 with cmd still 0101: DEAD for 8, then RAMP from 0.
- Mid-RAMP left (1010), reset for 1 clock.
  - All outputs, duty, pwm_cnt and cmd are 0.
  - Full re-acceptance latency of 7 edges applies after release.
